// File: rtl/key_scan_ctrl_pkg.sv
// key_pkg: types and default parameters shared by the key scan controller.
//   key_code_t  - 4-bit BCD key code (0..9)
//   key_state_t - scan FSM states
//   DEB_CYCLES_DEF / FIFO_DEPTH_DEF - default debounce length and queue depth
package key_pkg;

    localparam int unsigned DEB_CYCLES_DEF = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEBOUNCE    = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_DEB = 2'd3
    } key_state_t;

endpackage

// File: rtl/key_scan_ctrl_if.sv
// key_scan_ctrl_if: key-event stream from the scan controller to its consumer.
//   key_code  - code of the head event (0 when the queue is empty)
//   key_valid - queue holds at least one event
//   key_ready - consumer takes the head event when key_valid is high
// master: event producer (key_scan_ctrl); slave: consumer.
interface key_scan_ctrl_if;
    import key_pkg::*;

    key_code_t key_code;
    logic      key_valid;
    logic      key_ready;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready
    );

endinterface

// File: rtl/key_scan_ctrl_enc.sv
// key_encoder: combinational 10-to-4 priority encoder for active-low lines.
//   S_n - active-low key lines, S_n[9] has highest priority
//   L   - code of the highest-index low line, 0 when none is low
//   GS  - high when any line is low
module key_encoder
    import key_pkg::*;
(
    input  logic [9:0] S_n,
    output key_code_t  L,
    output logic       GS
);

    // Ascending scan: a later (higher) low line overrides earlier ones.
    always_comb begin
        L  = '0;
        GS = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (!S_n[i]) begin
                L  = key_code_t'(i);
                GS = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// key_scan_ctrl: debounced 10-key keypad scanner with an event queue.
//   clk, rst_n - clock and asynchronous active-low reset
//   S_n        - raw active-low key lines (asynchronous, bouncing)
//   kif        - key event stream (key_code / key_valid / key_ready)
//   busy       - FSM is not idle
//   overflow   - sticky: an accepted press was lost because the queue was full
module key_scan_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [9:0]      S_n,
    key_scan_ctrl_if.master kif,
    output logic            busy,
    output logic            overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [7:0]  DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [9:0]    sync1_q, sync2_q;
    key_code_t     enc_code;
    logic          enc_gs;

    key_state_t    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    key_code_t     cand_q, cand_d;
    logic          push;

    key_code_t     mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    logic          not_empty, full, pop, wr_en;

    // Two-flop synchronizer; idle (released) level is all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= S_n;
            sync2_q <= sync1_q;
        end
    end

    key_encoder u_enc (
        .S_n (sync2_q),
        .L   (enc_code),
        .GS  (enc_gs)
    );

    // Debounce FSM: the entry cycle into DEBOUNCE / RELEASE_DEB is not counted,
    // so acceptance needs DEB_CYCLES further qualifying cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_gs) begin
                    state_d = ST_DEBOUNCE;
                    cand_d  = enc_code;
                    cnt_d   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (enc_gs && (enc_code == cand_q)) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                        push    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_PRESSED: begin
                if (!enc_gs) begin
                    state_d = ST_RELEASE_DEB;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_DEB: begin
                if (enc_gs) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Event queue. A pop frees a slot on the same edge, so a push into a full
    // queue still succeeds when the head is consumed at the same time.
    assign not_empty = (count_q != '0);
    assign full      = (count_q == FULL_CNT);
    assign pop       = not_empty && kif.key_ready;
    assign wr_en     = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible behind count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= cand_q;
        end
    end

    assign kif.key_valid = not_empty;
    assign kif.key_code  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign busy          = (state_q != ST_IDLE);
    assign overflow      = ovf_q;

endmodule
